// File: rtl/editor_pkg.sv
// Shared types and constants for the keyboard-driven date/time editor.
package editor_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_WRITE,
        S_ACK_HI,
        S_ACK_LO,
        S_RELEASE
    } state_t;

    // CMD bit positions: {UP,DO,RI,LE,TO,AS}, MSB first
    localparam int unsigned CMD_AS = 0;
    localparam int unsigned CMD_TO = 1;
    localparam int unsigned CMD_LE = 2;
    localparam int unsigned CMD_RI = 3;
    localparam int unsigned CMD_DO = 4;
    localparam int unsigned CMD_UP = 5;

    localparam int unsigned NUM_FIELDS = 6;

    localparam logic [2:0] F_SEC   = 3'd0;
    localparam logic [2:0] F_MIN   = 3'd1;
    localparam logic [2:0] F_HR    = 3'd2;
    localparam logic [2:0] F_DAY   = 3'd3;
    localparam logic [2:0] F_MONTH = 3'd4;
    localparam logic [2:0] F_YEAR  = 3'd5;

    localparam logic [7:0] DEFAULT_ADDR_BASE = 8'h21;

    function automatic logic [7:0] field_min(input logic [2:0] idx);
        case (idx)
            F_DAY, F_MONTH: return 8'h01;
            default:        return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] field_max(input logic [2:0] idx);
        case (idx)
            F_SEC, F_MIN: return 8'h59;
            F_HR:         return 8'h23;
            F_DAY:        return 8'h31;
            F_MONTH:      return 8'h12;
            default:      return 8'h99;
        endcase
    endfunction

endpackage

// File: rtl/editor_teclado_ctrl_bcd_field_step.sv
// One-step BCD increment/decrement with wrap between a field's min and max.
module bcd_field_step (
    input  logic [7:0] value,
    input  logic [7:0] min,
    input  logic [7:0] max,
    input  logic       dir,
    output logic [7:0] result
);

    always_comb begin
        result = value;
        if (dir) begin
            if (value == max)
                result = min;
            else if (value[3:0] == 4'd9)
                result = {value[7:4] + 4'd1, 4'd0};
            else
                result = {value[7:4], value[3:0] + 4'd1};
        end else begin
            if (value == min)
                result = max;
            else if (value[3:0] == 4'd0)
                result = {value[7:4] - 4'd1, 4'd9};
            else
                result = {value[7:4], value[3:0] - 4'd1};
        end
    end

endmodule

// File: rtl/editor_teclado_ctrl.sv
// Keyboard command sequencer: edits six BCD date/time fields and issues RTC writes.
// Optional write watchdog enabled by defining WATCHDOG_EN.
module editor_teclado_ctrl
    import editor_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [7:0]  ADDR_BASE      = DEFAULT_ADDR_BASE
) (
    input  logic       Reloj,
    input  logic       RST_n,
    input  logic [5:0] CMD,
    output logic       S_DATA,
    output logic       EDIT_MODE,
    output logic [2:0] CURSOR,
    output logic [7:0] FIELD_VAL,
    output logic       WR_REQ,
    output logic [7:0] WR_ADDR,
    output logic [7:0] WR_DATA,
    input  logic       WR_ACK,
    output logic       WR_ERR,
    output logic       ALARM_STOP
);

    state_t     state, state_nx;
    logic [5:0] cmd_q;
    logic [7:0] fields [NUM_FIELDS];
    logic       edit_q, alarm_q;
    logic [2:0] cursor_q;
    logic [7:0] addr_q, data_q;
    logic [7:0] step_val;
    logic       do_as, do_to, do_step, do_cur, step_up, cur_up;
    logic       wd_expire;

    bcd_field_step u_step (
        .value  (fields[cursor_q]),
        .min    (field_min(cursor_q)),
        .max    (field_max(cursor_q)),
        .dir    (step_up),
        .result (step_val)
    );

    // Only the highest-priority bit of the latched command acts; the rest are dropped
    always_comb begin
        do_as   = 1'b0;
        do_to   = 1'b0;
        do_step = 1'b0;
        do_cur  = 1'b0;
        step_up = 1'b1;
        cur_up  = 1'b1;
        if (cmd_q[CMD_AS])
            do_as = 1'b1;
        else if (cmd_q[CMD_TO])
            do_to = 1'b1;
        else if (cmd_q[CMD_UP])
            do_step = edit_q;
        else if (cmd_q[CMD_DO]) begin
            do_step = edit_q;
            step_up = 1'b0;
        end else if (cmd_q[CMD_RI])
            do_cur = edit_q;
        else if (cmd_q[CMD_LE]) begin
            do_cur = edit_q;
            cur_up = 1'b0;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (CMD != '0) state_nx = S_DECODE;
            S_DECODE:  state_nx = do_step ? S_WRITE : S_ACK_HI;
            S_WRITE:   if (WR_ACK || wd_expire) state_nx = S_ACK_HI;
            S_ACK_HI:  state_nx = S_ACK_LO;
            S_ACK_LO:  state_nx = S_RELEASE;
            S_RELEASE: if (CMD == '0) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge Reloj or negedge RST_n) begin
        if (!RST_n)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge Reloj or negedge RST_n) begin
        if (!RST_n) begin
            cmd_q    <= '0;
            edit_q   <= 1'b0;
            cursor_q <= F_SEC;
            alarm_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            for (int unsigned i = 0; i < NUM_FIELDS; i++)
                fields[i] <= field_min(3'(i));
        end else begin
            alarm_q <= 1'b0;
            if (state == S_IDLE && CMD != '0)
                cmd_q <= CMD;
            if (state == S_DECODE) begin
                alarm_q <= do_as;
                if (do_to)
                    edit_q <= ~edit_q;
                if (do_cur) begin
                    if (cur_up)
                        cursor_q <= (cursor_q == F_YEAR) ? F_SEC : cursor_q + 3'd1;
                    else
                        cursor_q <= (cursor_q == F_SEC) ? F_YEAR : cursor_q - 3'd1;
                end
                if (do_step) begin
                    fields[cursor_q] <= step_val;
                    addr_q           <= ADDR_BASE + {5'd0, cursor_q};
                    data_q           <= step_val;
                end
            end
        end
    end

`ifdef WATCHDOG_EN
    logic [31:0] wd_cnt;
    logic        err_q;

    // An ACK arriving on the expiry cycle still counts as a successful write
    assign wd_expire = (state == S_WRITE) && !WR_ACK
                       && (wd_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Reloj or negedge RST_n) begin
        if (!RST_n) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q  <= wd_expire;
            wd_cnt <= (state == S_WRITE) ? wd_cnt + 32'd1 : '0;
        end
    end

    assign WR_ERR = err_q;
`else
    assign wd_expire = 1'b0;
    assign WR_ERR    = 1'b0;
`endif

    assign S_DATA     = (state == S_ACK_HI);
    assign WR_REQ     = (state == S_WRITE);
    assign WR_ADDR    = addr_q;
    assign WR_DATA    = data_q;
    assign EDIT_MODE  = edit_q;
    assign CURSOR     = cursor_q;
    assign FIELD_VAL  = fields[cursor_q];
    assign ALARM_STOP = alarm_q;

endmodule

// File: tb/tb_editor_teclado_ctrl.sv
// Randomized self-checking bench for editor_teclado_ctrl against a decimal-arithmetic model.
module tb_editor_teclado_ctrl;

    localparam int TO_CYC = 16;

    logic       Reloj = 1'b0;
    logic       RST_n;
    logic [5:0] CMD;
    logic       S_DATA, EDIT_MODE, WR_REQ, WR_ACK, WR_ERR, ALARM_STOP;
    logic [2:0] CURSOR;
    logic [7:0] FIELD_VAL, WR_ADDR, WR_DATA;

    int n_checks = 0;
    int n_fail   = 0;

    int FMIN [6] = '{0, 0, 0, 1, 1, 0};
    int FMAX [6] = '{59, 59, 23, 31, 12, 99};
    int m_f  [6];
    bit m_edit;
    int m_cur;

    editor_teclado_ctrl #(
        .TIMEOUT_CYCLES (TO_CYC),
        .ADDR_BASE      (8'h21)
    ) dut (
        .Reloj      (Reloj),
        .RST_n      (RST_n),
        .CMD        (CMD),
        .S_DATA     (S_DATA),
        .EDIT_MODE  (EDIT_MODE),
        .CURSOR     (CURSOR),
        .FIELD_VAL  (FIELD_VAL),
        .WR_REQ     (WR_REQ),
        .WR_ADDR    (WR_ADDR),
        .WR_DATA    (WR_DATA),
        .WR_ACK     (WR_ACK),
        .WR_ERR     (WR_ERR),
        .ALARM_STOP (ALARM_STOP)
    );

    always #5 Reloj = ~Reloj;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_f[i] = FMIN[i];
        m_edit = 1'b0;
        m_cur  = 0;
    endtask

    // dly < 0 means never acknowledge (watchdog path)
    task automatic exec(input logic [5:0] c, input int dly);
        int         act;
        bit         up;
        int         v;
        logic [7:0] exp_addr, exp_data;
        act = 0; up = 1'b0; exp_addr = '0; exp_data = '0;
        if (c[0])      act = 1;
        else if (c[1]) act = 2;
        else if (c[5]) begin act = m_edit ? 3 : 0; up = 1'b1; end
        else if (c[4]) act = m_edit ? 3 : 0;
        else if (c[3]) begin act = m_edit ? 4 : 0; up = 1'b1; end
        else if (c[2]) act = m_edit ? 4 : 0;
        case (act)
            2: m_edit = !m_edit;
            3: begin
                v = m_f[m_cur];
                if (up) v = (v == FMAX[m_cur]) ? FMIN[m_cur] : v + 1;
                else    v = (v == FMIN[m_cur]) ? FMAX[m_cur] : v - 1;
                m_f[m_cur] = v;
                exp_addr = 8'(33 + m_cur);
                exp_data = to_bcd(v);
            end
            4: m_cur = up ? (m_cur + 1) % 6 : (m_cur + 5) % 6;
            default: ;
        endcase

        @(negedge Reloj); CMD = c;
        @(posedge Reloj); #1;
        chk("decode_quiet", 32'({S_DATA, WR_REQ, ALARM_STOP}), 32'd0);
        @(posedge Reloj); #1;
        chk("alarm_stop", 32'(ALARM_STOP), 32'(act == 1));
        chk("edit_mode", 32'(EDIT_MODE), 32'(m_edit));
        chk("cursor", 32'(CURSOR), 32'(m_cur));
        chk("field_val", 32'(FIELD_VAL), 32'(to_bcd(m_f[m_cur])));
        if (act == 3) begin
            chk("wr_req_rise", 32'(WR_REQ), 32'd1);
            chk("wr_addr", 32'(WR_ADDR), 32'(exp_addr));
            chk("wr_data", 32'(WR_DATA), 32'(exp_data));
            chk("sdata_in_write", 32'(S_DATA), 32'd0);
            if (dly < 0) begin
                for (int k = 0; k < TO_CYC - 1; k++) begin
                    @(posedge Reloj); #1;
                    chk("wd_hold", 32'(WR_REQ), 32'd1);
                end
                @(posedge Reloj); #1;
                chk("wd_req_drop", 32'(WR_REQ), 32'd0);
                chk("wd_err", 32'(WR_ERR), 32'd1);
                chk("wd_sdata", 32'(S_DATA), 32'd1);
            end else begin
                for (int k = 0; k < dly; k++) begin
                    @(posedge Reloj); #1;
                    chk("wr_hold", 32'(WR_REQ), 32'd1);
                    chk("wr_data_stable", 32'({WR_ADDR, WR_DATA}), 32'({exp_addr, exp_data}));
                end
                @(negedge Reloj); WR_ACK = 1'b1;
                @(posedge Reloj); #1; WR_ACK = 1'b0;
                chk("wr_req_drop", 32'(WR_REQ), 32'd0);
                chk("ack_sdata_hi", 32'(S_DATA), 32'd1);
                chk("wr_err_quiet", 32'(WR_ERR), 32'd0);
            end
        end else begin
            chk("no_wr_req", 32'(WR_REQ), 32'd0);
            chk("sdata_hi", 32'(S_DATA), 32'd1);
        end
        @(posedge Reloj); #1;
        chk("sdata_lo", 32'({S_DATA, ALARM_STOP, WR_ERR}), 32'd0);
        repeat ($urandom_range(0, 3)) begin
            @(posedge Reloj); #1;
            chk("no_repeat", 32'({S_DATA, WR_REQ, ALARM_STOP}), 32'd0);
        end
        @(negedge Reloj); CMD = '0;
        @(posedge Reloj);
        @(posedge Reloj); #1;
        chk("idle_quiet", 32'({S_DATA, WR_REQ}), 32'd0);
    endtask

    initial begin
        logic [5:0] c;
        int         d;
        RST_n = 1'b0; CMD = '0; WR_ACK = 1'b0;
        model_reset();
        #12;
        chk("rst_outs", 32'({S_DATA, EDIT_MODE, CURSOR, WR_REQ, WR_ERR, ALARM_STOP}), 32'd0);
        chk("rst_wr_bus", 32'({WR_ADDR, WR_DATA}), 32'd0);
        chk("rst_field", 32'(FIELD_VAL), 32'h00);
        @(negedge Reloj); RST_n = 1'b1;

        exec(6'b000010, 0);   // TO: enter edit mode
        exec(6'b010000, 3);   // DO: sec 00 -> 59
        exec(6'b100000, 3);   // UP: sec 59 -> 00
        exec(6'b000100, 0);   // LE: cursor 0 -> 5
        exec(6'b010000, 0);   // DO: year 00 -> 99, ack on rise cycle
        exec(6'b000010, 1);   // leave edit mode
        exec(6'b100001, 0);   // UP+AS with edit off
`ifdef WATCHDOG_EN
        exec(6'b000010, 0);
        exec(6'b100000, -1);
`endif

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 1) == 1) c = 6'(1 << $urandom_range(0, 5));
            else                           c = 6'($urandom_range(1, 63));
            d = $urandom_range(0, 4);
`ifdef WATCHDOG_EN
            if ($urandom_range(0, 7) == 0) d = -1;
`endif
            exec(c, d);
        end

        if (!m_edit) exec(6'b000010, 0);
        @(negedge Reloj); CMD = 6'b100000;
        @(posedge Reloj);
        @(posedge Reloj); #1;
        chk("rst_pre_req", 32'(WR_REQ), 32'd1);
        #2 RST_n = 1'b0;
        #1;
        chk("rst_async_req", 32'(WR_REQ), 32'd0);
        chk("rst_async_outs", 32'({S_DATA, EDIT_MODE, CURSOR, WR_ADDR, WR_DATA}), 32'd0);
        chk("rst_async_field", 32'(FIELD_VAL), 32'h00);
        model_reset();
        @(negedge Reloj); RST_n = 1'b1;
        @(posedge Reloj);
        @(posedge Reloj); #1;
        chk("reexec_sdata", 32'(S_DATA), 32'd1);
        chk("reexec_no_req", 32'(WR_REQ), 32'd0);
        @(posedge Reloj); #1;
        @(negedge Reloj); CMD = '0;
        @(posedge Reloj);
        @(posedge Reloj);
        exec(6'b000010, 0);
        exec(6'b001000, 0);
        exec(6'b100000, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/editor_teclado_ctrl.md
# editor_teclado_ctrl

Sequencer between the PS/2 keyboard translator and the RTC write controller. Consumes the translator's one-hot key command, acknowledges it through the translator's S_DATA clear handshake, and maintains an edit cursor over six BCD date/time fields. Each accepted UP/DO edit issues one request/acknowledge write transaction to the RTC controller.

## Interface
- TIMEOUT_CYCLES, 1024: cycles WR_REQ may stay unacknowledged before abort (WATCHDOG_EN only).
- ADDR_BASE, 8'h21: RTC address of field 0. Field n is written at ADDR_BASE+n.
- Reloj  in  1  system clock, 100 MHz.
- RST_n  in  1  asynchronous, active-low reset.
- CMD  in  6  translator one-hot command {UP,DO,RI,LE,TO,AS}, MSB first; held until cleared.
- S_DATA  out  1  clear strobe to translator; its falling edge clears CMD.
- EDIT_MODE  out  1  edit mode active.
- CURSOR  out  3  selected field: 0 sec, 1 min, 2 hr, 3 day, 4 month, 5 year.
- FIELD_VAL  out  8  BCD value of the selected field.
- WR_REQ  out  1  write request to the RTC controller.
- WR_ADDR  out  8  write address, valid while WR_REQ is high.
- WR_DATA  out  8  BCD write data, valid while WR_REQ is high.
- WR_ACK  in  1  RTC controller accept, single-cycle pulse.
- WR_ERR  out  1  one-cycle pulse on write timeout.
- ALARM_STOP  out  1  one-cycle pulse on the AS key.

## Operation
- Reset values:
  - Outputs: S_DATA=0, EDIT_MODE=0, CURSOR=0, WR_REQ=0, WR_ADDR=0, WR_DATA=0, WR_ERR=0, ALARM_STOP=0.
  - Fields: sec/min/hr=8'h00, day/month=8'h01, year=8'h00.
- States: IDLE, DECODE, WRITE, ACK_HI, ACK_LO, RELEASE.
- IDLE: when CMD != 0, latch CMD and go to DECODE.
- DECODE: act on the highest-priority set bit, priority AS > TO > UP > DO > RI > LE. Other bits are discarded.
  - AS: pulse ALARM_STOP in any mode; go to ACK_HI.
  - TO: toggle EDIT_MODE; go to ACK_HI.
  - UP/DO with EDIT_MODE=1: step the selected field ±1 in BCD, wrapping at its limits; load WR_ADDR/WR_DATA; go to WRITE.
  - RI/LE with EDIT_MODE=1: CURSOR +1/−1, wrapping 5→0 and 0→5; go to ACK_HI.
  - UP/DO/RI/LE with EDIT_MODE=0: no effect; go to ACK_HI.
- Field limits (BCD): sec 00–59, min 00–59, hr 00–23, day 01–31, month 01–12, year 00–99. DO from the minimum wraps to the maximum; UP from the maximum wraps to the minimum.
- WRITE: hold WR_REQ=1 with WR_ADDR/WR_DATA stable until WR_ACK=1, then go to ACK_HI. WR_ACK is ignored outside WRITE.
- ACK_HI: S_DATA=1 for exactly one cycle. ACK_LO: S_DATA=0, producing the falling edge.
- RELEASE: wait until CMD==0, then return to IDLE. A command never executes twice.

## Timing
- CMD sampled at edge N → DECODE at N+1 → WR_REQ high from N+2.
- WR_ACK seen at edge M → WR_REQ low at M+1 → S_DATA high at M+1 and low at M+2.
- Non-write command: ALARM_STOP, EDIT_MODE and CURSOR update at N+2; S_DATA high at N+2, low at N+3.
- The field register updates with WR_DATA at N+2, whether or not the write is later acknowledged.
- WR_ACK in the same cycle WR_REQ first rises is accepted.
- RST_n low at any point clears all state immediately, including mid-write (WR_REQ drops asynchronously). No clear strobe is sent; the pending CMD is re-executed after reset.

## Configuration
- WATCHDOG_EN defined: a counter runs in WRITE. On reaching TIMEOUT_CYCLES without WR_ACK:
  - WR_REQ drops and WR_ERR pulses for one cycle.
  - The FSM proceeds to ACK_HI.
  - The field keeps its new value.
- WATCHDOG_EN undefined: no counter. WRITE waits indefinitely and WR_ERR is tied to 0.

## Structure
- Package editor_pkg holds:
  - state encoding;
  - CMD bit indices;
  - field index constants;
  - per-field BCD min/max tables;
  - default ADDR_BASE.
- Sub-module bcd_field_step: inputs value, min, max, dir; output wrapped BCD ±1. Instantiated once, selected by CURSOR.

## Test plan
- Reset, then CMD=6'b000010 (TO) → EDIT_MODE=1, S_DATA pulse high 1 cycle; CMD cleared → IDLE.
- Edit mode, CURSOR=0, sec=8'h59, UP → WR_REQ with WR_ADDR=8'h21, WR_DATA=8'h00. WR_ACK after 3 cycles → WR_REQ low next cycle, then S_DATA pulse.
- Edit mode, LE at CURSOR=0 → CURSOR=5. Then DO with year=8'h00 → WR_ADDR=8'h26, WR_DATA=8'h99.
- EDIT_MODE=0, CMD=6'b100001 (UP+AS) → ALARM_STOP pulses once, no WR_REQ, fields unchanged.
- WATCHDOG_EN, TIMEOUT_CYCLES=16, UP with no WR_ACK → WR_ERR pulse 16 cycles after WR_REQ rises, then S_DATA pulse.
- RST_n low while WR_REQ=1 → WR_REQ=0 with no clock edge; all fields back to reset values.
